// File: rtl/ysyx_24110006_pkg.sv
// Shared definitions for the ysyx_24110006 instruction cache: FSM states,
// cacheable address window and AXI response codes.
package ysyx_24110006_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL_AR,
    REFILL_R,
    BYPASS_AR,
    BYPASS_R,
    RESP
  } state_e;

  localparam logic [31:0] CACHE_BASE  = 32'h8000_0000;
  localparam logic [31:0] CACHE_LIMIT = 32'h8FFF_FFFF;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  function automatic logic is_cacheable(input logic [31:0] addr);
    return (addr >= CACHE_BASE) && (addr <= CACHE_LIMIT);
  endfunction

endpackage

// File: rtl/ysyx_24110006_icache_array.sv
// Direct-mapped tag/data/valid storage: combinational read, one synchronous
// write port; valid bits cleared by reset or flush.
module ysyx_24110006_icache_array #(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = 4,
  parameter int WORD_W     = 2,
  parameter int TAG_W      = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [IDX_W-1:0]  rd_index,
  input  logic [WORD_W-1:0] rd_word,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [31:0]       rd_data,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [WORD_W-1:0] wr_word,
  input  logic              wr_data_en,
  input  logic [31:0]       wr_data,
  input  logic              wr_tag_en,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic              wr_valid
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [31:0]          data_mem [NUM_LINES][LINE_WORDS];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index][rd_word];

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (wr_tag_en) begin
      valid_q[wr_index] <= wr_valid;
    end
  end

  // NOTE: tag/data arrays are not reset; the valid bits alone decide whether contents are used.
  always_ff @(posedge clk) begin
    if (wr_tag_en) tag_mem[wr_index] <= wr_tag;
    if (wr_data_en) data_mem[wr_index][wr_word] <= wr_data;
  end

endmodule

// File: rtl/ysyx_24110006_icache.sv
// Direct-mapped, blocking instruction cache between the IFU and arbiter port 0.
// Define YSYX_24110006_ICACHE_PERF_EN to build the hit/miss counters.
module ysyx_24110006_icache
  import ysyx_24110006_pkg::*;
#(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_flush,
  input  logic [31:0] i_axi_araddr,
  input  logic        i_axi_arvalid,
  output logic        o_axi_arready,
  output logic [31:0] o_axi_rdata,
  output logic [1:0]  o_axi_rresp,
  output logic        o_axi_rvalid,
  input  logic        i_axi_rready,
  output logic [31:0] o_axi_araddr,
  output logic        o_axi_arvalid,
  input  logic        i_axi_arready,
  input  logic [31:0] i_axi_rdata,
  input  logic [1:0]  i_axi_rresp,
  input  logic        i_axi_rvalid,
  output logic        o_axi_rready,
  output logic [31:0] o_perf_hit,
  output logic [31:0] o_perf_miss
);

  localparam int OFF_W  = $clog2(LINE_WORDS * 4);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int WORD_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int TAG_W  = 32 - OFF_W - IDX_W;

  state_e            state;
  logic [31:0]       addr;
  logic [WORD_W-1:0] beat;
  logic [31:0]       word_q;
  logic              flush_seen;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WORD_W-1:0] word_off;
  logic [WORD_W-1:0] beat_nxt;
  logic [31:0]       line_base;
  logic              last_beat;

  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [31:0]       rd_data;
  logic              hit;

  logic              wr_data_en;
  logic              wr_tag_en;
  logic              wr_valid;

  assign idx       = addr[OFF_W +: IDX_W];
  assign tag       = addr[31 -: TAG_W];
  assign word_off  = WORD_W'((addr >> 2) & 32'(LINE_WORDS - 1));
  assign line_base = addr & ~32'(LINE_WORDS * 4 - 1);
  assign beat_nxt  = beat + 1'b1;
  assign last_beat = (beat == WORD_W'(LINE_WORDS - 1));
  assign hit       = rd_valid && (rd_tag == tag);

  ysyx_24110006_icache_array #(
    .NUM_LINES (NUM_LINES),
    .LINE_WORDS(LINE_WORDS),
    .IDX_W     (IDX_W),
    .WORD_W    (WORD_W),
    .TAG_W     (TAG_W)
  ) u_array (
    .clk       (i_clock),
    .rst_n     (i_reset),
    .flush     (i_flush),
    .rd_index  (idx),
    .rd_word   (word_off),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .wr_index  (idx),
    .wr_word   (beat),
    .wr_data_en(wr_data_en),
    .wr_data   (i_axi_rdata),
    .wr_tag_en (wr_tag_en),
    .wr_tag    (tag),
    .wr_valid  (wr_valid)
  );

  // A miss invalidates the victim line up front, so a partial or aborted
  // refill can never be mistaken for the old line.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_data_en = 1'b0;
    wr_tag_en  = 1'b0;
    wr_valid   = 1'b0;
    if (state == LOOKUP && !hit) begin
      wr_tag_en = 1'b1;
    end
    if (state == REFILL_R && i_axi_rvalid && i_axi_rresp == RESP_OKAY) begin
      wr_data_en = 1'b1;
      if (last_beat) begin
        wr_tag_en = 1'b1;
        wr_valid  = !flush_seen && !i_flush;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state         <= IDLE;
      addr          <= '0;
      beat          <= '0;
      word_q        <= '0;
      flush_seen    <= 1'b0;
      o_axi_arready <= 1'b1;
      o_axi_arvalid <= 1'b0;
      o_axi_araddr  <= '0;
      o_axi_rready  <= 1'b0;
      o_axi_rvalid  <= 1'b0;
      o_axi_rdata   <= '0;
      o_axi_rresp   <= RESP_OKAY;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_axi_arvalid) begin
            addr          <= i_axi_araddr;
            o_axi_arready <= 1'b0;
            if (is_cacheable(i_axi_araddr)) begin
              state <= LOOKUP;
            end else begin
              state         <= BYPASS_AR;
              o_axi_arvalid <= 1'b1;
              o_axi_araddr  <= i_axi_araddr;
            end
          end
        end
        LOOKUP: begin
          if (hit) begin
            state        <= RESP;
            o_axi_rvalid <= 1'b1;
            o_axi_rdata  <= rd_data;
            o_axi_rresp  <= RESP_OKAY;
          end else begin
            state         <= REFILL_AR;
            beat          <= '0;
            flush_seen    <= i_flush;
            o_axi_arvalid <= 1'b1;
            o_axi_araddr  <= line_base;
          end
        end
        REFILL_AR: begin
          if (i_flush) flush_seen <= 1'b1;
          if (i_axi_arready) begin
            state         <= REFILL_R;
            o_axi_arvalid <= 1'b0;
            o_axi_araddr  <= '0;
            o_axi_rready  <= 1'b1;
          end
        end
        REFILL_R: begin
          if (i_flush) flush_seen <= 1'b1;
          if (i_axi_rvalid) begin
            o_axi_rready <= 1'b0;
            if (i_axi_rresp != RESP_OKAY) begin
              state        <= RESP;
              o_axi_rvalid <= 1'b1;
              o_axi_rdata  <= '0;
              o_axi_rresp  <= i_axi_rresp;
            end else if (last_beat) begin
              state        <= RESP;
              o_axi_rvalid <= 1'b1;
              o_axi_rdata  <= (beat == word_off) ? i_axi_rdata : word_q;
              o_axi_rresp  <= RESP_OKAY;
            end else begin
              if (beat == word_off) word_q <= i_axi_rdata;
              state         <= REFILL_AR;
              beat          <= beat_nxt;
              o_axi_arvalid <= 1'b1;
              o_axi_araddr  <= line_base | (32'(beat_nxt) << 2);
            end
          end
        end
        BYPASS_AR: begin
          if (i_axi_arready) begin
            state         <= BYPASS_R;
            o_axi_arvalid <= 1'b0;
            o_axi_araddr  <= '0;
            o_axi_rready  <= 1'b1;
          end
        end
        BYPASS_R: begin
          if (i_axi_rvalid) begin
            state        <= RESP;
            o_axi_rready <= 1'b0;
            o_axi_rvalid <= 1'b1;
            o_axi_rdata  <= i_axi_rdata;
            o_axi_rresp  <= i_axi_rresp;
          end
        end
        RESP: begin
          // arready rises only after the response leaves, so no AR overlaps RESP.
          if (i_axi_rready) begin
            state         <= IDLE;
            o_axi_rvalid  <= 1'b0;
            o_axi_rdata   <= '0;
            o_axi_rresp   <= RESP_OKAY;
            o_axi_arready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef YSYX_24110006_ICACHE_PERF_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == LOOKUP) begin
      if (hit) hit_cnt <= hit_cnt + 32'd1;
      else     miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign o_perf_hit  = hit_cnt;
  assign o_perf_miss = miss_cnt;
`else
  assign o_perf_hit  = '0;
  assign o_perf_miss = '0;
`endif

endmodule

// File: tb/tb_ysyx_24110006_icache.sv
// Directed bench for ysyx_24110006_icache with a small downstream memory that
// returns addr + 0x1000_0000 and can inject SLVERR on one address.
module tb_ysyx_24110006_icache;

`ifdef YSYX_24110006_ICACHE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_flush;
  logic [31:0] i_axi_araddr;
  logic        i_axi_arvalid;
  logic        o_axi_arready;
  logic [31:0] o_axi_rdata;
  logic [1:0]  o_axi_rresp;
  logic        o_axi_rvalid;
  logic        i_axi_rready;
  logic [31:0] o_axi_araddr;
  logic        o_axi_arvalid;
  logic        i_axi_arready;
  logic [31:0] i_axi_rdata;
  logic [1:0]  i_axi_rresp;
  logic        i_axi_rvalid;
  logic        o_axi_rready;
  logic [31:0] o_perf_hit;
  logic [31:0] o_perf_miss;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] ar_log[$];
  logic [31:0] err_addr = 32'h0;
  logic        pending  = 1'b0;
  logic [31:0] pend_addr;

  always #5 clk = ~clk;

  ysyx_24110006_icache dut (
    .i_clock      (clk),
    .i_reset      (i_reset),
    .i_flush      (i_flush),
    .i_axi_araddr (i_axi_araddr),
    .i_axi_arvalid(i_axi_arvalid),
    .o_axi_arready(o_axi_arready),
    .o_axi_rdata  (o_axi_rdata),
    .o_axi_rresp  (o_axi_rresp),
    .o_axi_rvalid (o_axi_rvalid),
    .i_axi_rready (i_axi_rready),
    .o_axi_araddr (o_axi_araddr),
    .o_axi_arvalid(o_axi_arvalid),
    .i_axi_arready(i_axi_arready),
    .i_axi_rdata  (i_axi_rdata),
    .i_axi_rresp  (i_axi_rresp),
    .i_axi_rvalid (i_axi_rvalid),
    .o_axi_rready (o_axi_rready),
    .o_perf_hit   (o_perf_hit),
    .o_perf_miss  (o_perf_miss)
  );

  // Downstream memory: arready one cycle after arvalid, data once rready is up.
  initial begin
    i_axi_arready = 1'b0;
    i_axi_rvalid  = 1'b0;
    i_axi_rdata   = '0;
    i_axi_rresp   = 2'd0;
    forever begin
      @(negedge clk);
      if (i_axi_arready) begin
        i_axi_arready = 1'b0;
      end else if (o_axi_arvalid === 1'b1) begin
        i_axi_arready = 1'b1;
        ar_log.push_back(o_axi_araddr);
        pend_addr = o_axi_araddr;
        pending   = 1'b1;
      end
      if (i_axi_rvalid) begin
        i_axi_rvalid = 1'b0;
        i_axi_rdata  = '0;
        i_axi_rresp  = 2'd0;
      end else if (pending && o_axi_rready === 1'b1) begin
        i_axi_rvalid = 1'b1;
        i_axi_rdata  = pend_addr + 32'h1000_0000;
        i_axi_rresp  = (pend_addr == err_addr) ? 2'd2 : 2'd0;
        pending      = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] exp_cnt(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  task automatic send_ar(input logic [31:0] a);
    int waited = 0;
    @(negedge clk);
    i_axi_araddr  = a;
    i_axi_arvalid = 1'b1;
    while (o_axi_arready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (o_axi_arready !== 1'b1) begin
      n_checks++;
      $display("FAIL ar_handshake addr=%h got arready=%b want 1", a, o_axi_arready);
    end
    @(posedge clk);
    #1;
    i_axi_arvalid = 1'b0;
    i_axi_araddr  = '0;
  endtask

  task automatic wait_rvalid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (o_axi_rvalid !== 1'b1 && lat < 300);
    if (o_axi_rvalid !== 1'b1) begin
      n_checks++;
      $display("FAIL rvalid_timeout got rvalid=%b want 1", o_axi_rvalid);
    end
  endtask

  task automatic accept();
    i_axi_rready = 1'b1;
    @(posedge clk);
    #1;
    i_axi_rready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                         output int lat, output logic arr);
    send_ar(a);
    wait_rvalid(lat);
    d   = o_axi_rdata;
    r   = o_axi_rresp;
    arr = o_axi_arready;
    accept();
  endtask

  task automatic test_reset();
    i_reset       = 1'b0;
    i_flush       = 1'b0;
    i_axi_araddr  = '0;
    i_axi_arvalid = 1'b0;
    i_axi_rready  = 1'b0;
    repeat (3) @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    n_checks++; if (o_axi_arready !== 1'b1) $display("FAIL reset_arready got=%b want=1", o_axi_arready); else n_pass++;
    n_checks++; if (o_axi_rvalid !== 1'b0) $display("FAIL reset_rvalid got=%b want=0", o_axi_rvalid); else n_pass++;
    n_checks++; if (o_axi_arvalid !== 1'b0) $display("FAIL reset_arvalid got=%b want=0", o_axi_arvalid); else n_pass++;
    n_checks++; if (o_axi_rready !== 1'b0) $display("FAIL reset_rready got=%b want=0", o_axi_rready); else n_pass++;
    n_checks++; if (o_axi_rdata !== 32'h0) $display("FAIL reset_rdata got=%h want=0", o_axi_rdata); else n_pass++;
    n_checks++; if (o_axi_araddr !== 32'h0) $display("FAIL reset_araddr got=%h want=0", o_axi_araddr); else n_pass++;
    n_checks++; if (o_perf_hit !== 32'h0 || o_perf_miss !== 32'h0)
      $display("FAIL reset_perf got hit=%h miss=%h want 0/0", o_perf_hit, o_perf_miss); else n_pass++;
  endtask

  task automatic test_miss_refill();
    logic [31:0] d; logic [1:0] r; int lat; logic arr;
    ar_log.delete();
    do_read(32'h8000_0010, d, r, lat, arr);
    n_checks++; if (ar_log.size() != 4) $display("FAIL miss_ar_count got=%0d want=4", ar_log.size()); else n_pass++;
    n_checks++; if (ar_log[0] !== 32'h8000_0010) $display("FAIL miss_ar0 got=%h want=80000010", ar_log[0]); else n_pass++;
    n_checks++; if (ar_log[1] !== 32'h8000_0014) $display("FAIL miss_ar1 got=%h want=80000014", ar_log[1]); else n_pass++;
    n_checks++; if (ar_log[2] !== 32'h8000_0018) $display("FAIL miss_ar2 got=%h want=80000018", ar_log[2]); else n_pass++;
    n_checks++; if (ar_log[3] !== 32'h8000_001C) $display("FAIL miss_ar3 got=%h want=8000001c", ar_log[3]); else n_pass++;
    n_checks++; if (d !== 32'h9000_0010) $display("FAIL miss_rdata got=%h want=90000010", d); else n_pass++;
    n_checks++; if (r !== 2'd0) $display("FAIL miss_rresp got=%0d want=0", r); else n_pass++;
    n_checks++; if (o_perf_miss !== exp_cnt(1)) $display("FAIL miss_count got=%0d want=%0d", o_perf_miss, exp_cnt(1)); else n_pass++;
  endtask

  task automatic test_hit();
    logic [31:0] d; logic [1:0] r; int lat; logic arr;
    ar_log.delete();
    do_read(32'h8000_0014, d, r, lat, arr);
    n_checks++; if (ar_log.size() != 0) $display("FAIL hit_ar_count got=%0d want=0", ar_log.size()); else n_pass++;
    n_checks++; if (lat != 2) $display("FAIL hit_latency got=%0d want=2", lat); else n_pass++;
    n_checks++; if (d !== 32'h9000_0014) $display("FAIL hit_rdata got=%h want=90000014", d); else n_pass++;
    n_checks++; if (arr !== 1'b0) $display("FAIL hit_arready_in_resp got=%b want=0", arr); else n_pass++;
    n_checks++; if (o_perf_hit !== exp_cnt(1)) $display("FAIL hit_count got=%0d want=%0d", o_perf_hit, exp_cnt(1)); else n_pass++;
    n_checks++; if (o_axi_arready !== 1'b1) $display("FAIL hit_back_to_idle got=%b want=1", o_axi_arready); else n_pass++;
  endtask

  task automatic test_evict();
    logic [31:0] d; logic [1:0] r; int lat; logic arr;
    ar_log.delete();
    do_read(32'h8000_0110, d, r, lat, arr);
    n_checks++; if (ar_log.size() != 4 || ar_log[0] !== 32'h8000_0110)
      $display("FAIL evict_ar got n=%0d first=%h want n=4 first=80000110", ar_log.size(), ar_log[0]); else n_pass++;
    n_checks++; if (d !== 32'h9000_0110) $display("FAIL evict_rdata got=%h want=90000110", d); else n_pass++;
    ar_log.delete();
    do_read(32'h8000_0010, d, r, lat, arr);
    n_checks++; if (ar_log.size() != 4) $display("FAIL evict_remiss_ar got=%0d want=4", ar_log.size()); else n_pass++;
    n_checks++; if (d !== 32'h9000_0010) $display("FAIL evict_remiss_rdata got=%h want=90000010", d); else n_pass++;
    n_checks++; if (o_perf_miss !== exp_cnt(3)) $display("FAIL evict_miss_count got=%0d want=%0d", o_perf_miss, exp_cnt(3)); else n_pass++;
  endtask

  task automatic test_bypass();
    logic [31:0] d; logic [1:0] r; int lat; logic arr;
    ar_log.delete();
    do_read(32'hA000_0048, d, r, lat, arr);
    n_checks++; if (ar_log.size() != 1) $display("FAIL bypass_ar_count got=%0d want=1", ar_log.size()); else n_pass++;
    n_checks++; if (ar_log[0] !== 32'hA000_0048) $display("FAIL bypass_ar_addr got=%h want=a0000048", ar_log[0]); else n_pass++;
    n_checks++; if (d !== 32'hB000_0048) $display("FAIL bypass_rdata got=%h want=b0000048", d); else n_pass++;
    n_checks++; if (o_perf_hit !== exp_cnt(1) || o_perf_miss !== exp_cnt(3))
      $display("FAIL bypass_counters got hit=%0d miss=%0d want %0d/%0d", o_perf_hit, o_perf_miss, exp_cnt(1), exp_cnt(3)); else n_pass++;
  endtask

  task automatic test_refill_error();
    logic [31:0] d; logic [1:0] r; int lat; logic arr;
    err_addr = 32'h8000_0228;
    ar_log.delete();
    do_read(32'h8000_0224, d, r, lat, arr);
    n_checks++; if (ar_log.size() != 3) $display("FAIL err_ar_count got=%0d want=3", ar_log.size()); else n_pass++;
    n_checks++; if (ar_log[2] !== 32'h8000_0228) $display("FAIL err_ar2 got=%h want=80000228", ar_log[2]); else n_pass++;
    n_checks++; if (r !== 2'd2) $display("FAIL err_rresp got=%0d want=2", r); else n_pass++;
    n_checks++; if (d !== 32'h0) $display("FAIL err_rdata got=%h want=0", d); else n_pass++;
    err_addr = 32'h0;
    ar_log.delete();
    do_read(32'h8000_0224, d, r, lat, arr);
    n_checks++; if (ar_log.size() != 4) $display("FAIL err_refetch_ar got=%0d want=4", ar_log.size()); else n_pass++;
    n_checks++; if (d !== 32'h9000_0224 || r !== 2'd0)
      $display("FAIL err_refetch_data got=%h/%0d want=90000224/0", d, r); else n_pass++;
  endtask

  task automatic test_flush_refill();
    logic [31:0] d; logic [1:0] r; int lat; logic arr;
    int waited = 0;
    ar_log.delete();
    send_ar(32'h8000_0330);
    while (o_axi_rready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    n_checks++; if (o_axi_rready !== 1'b1) $display("FAIL flush_reach_refill_r got=%b want=1", o_axi_rready); else n_pass++;
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    wait_rvalid(lat);
    n_checks++; if (o_axi_rdata !== 32'h9000_0330) $display("FAIL flush_rdata got=%h want=90000330", o_axi_rdata); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (o_axi_rvalid !== 1'b1) $display("FAIL hold_rvalid[%0d] got=%b want=1", i, o_axi_rvalid); else n_pass++;
      n_checks++; if (o_axi_rdata !== 32'h9000_0330) $display("FAIL hold_rdata[%0d] got=%h want=90000330", i, o_axi_rdata); else n_pass++;
    end
    accept();
    ar_log.delete();
    do_read(32'h8000_0330, d, r, lat, arr);
    n_checks++; if (ar_log.size() != 4) $display("FAIL flush_remiss_ar got=%0d want=4", ar_log.size()); else n_pass++;
    n_checks++; if (d !== 32'h9000_0330) $display("FAIL flush_remiss_rdata got=%h want=90000330", d); else n_pass++;
    ar_log.delete();
    do_read(32'h8000_0010, d, r, lat, arr);
    n_checks++; if (ar_log.size() != 4) $display("FAIL flush_cleared_other_ar got=%0d want=4", ar_log.size()); else n_pass++;
    n_checks++; if (o_perf_miss !== exp_cnt(8)) $display("FAIL flush_miss_count got=%0d want=%0d", o_perf_miss, exp_cnt(8)); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic [1:0] r; int lat; logic arr;
    ar_log.delete();
    do_read(32'h8000_0334, d, r, lat, arr);
    n_checks++; if (lat != 2 || d !== 32'h9000_0334)
      $display("FAIL b2b_hit0 got lat=%0d d=%h want 2/90000334", lat, d); else n_pass++;
    do_read(32'h8000_033C, d, r, lat, arr);
    n_checks++; if (lat != 2 || d !== 32'h9000_033C)
      $display("FAIL b2b_hit1 got lat=%0d d=%h want 2/9000033c", lat, d); else n_pass++;
    n_checks++; if (ar_log.size() != 0) $display("FAIL b2b_ar_count got=%0d want=0", ar_log.size()); else n_pass++;
    n_checks++; if (o_perf_hit !== exp_cnt(3)) $display("FAIL b2b_hit_count got=%0d want=%0d", o_perf_hit, exp_cnt(3)); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_miss_refill();
    test_hit();
    test_evict();
    test_bypass();
    test_refill_error();
    test_flush_refill();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_24110006_icache.md
YSYX_24110006_ICACHE -- requirements
Module: ysyx_24110006_icache

Interface
REQ-001 SHALL have parameter NUM_LINES, default 16, meaning the number of direct-mapped lines (power of 2, 2..256).
REQ-002 SHALL have parameter LINE_WORDS, default 4, meaning 32-bit words per line (power of 2, 1..8).
REQ-003 SHALL have port i_clock, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_reset, input, 1, synchronous active-low reset.
REQ-005 SHALL have port i_flush, input, 1, a one-cycle invalidate-all pulse (fence.i).
REQ-006 SHALL have ports i_axi_araddr (in, 32), i_axi_arvalid (in, 1) and o_axi_arready (out, 1), forming the upstream read-address channel from the IFU.
REQ-007 SHALL have ports o_axi_rdata (out, 32), o_axi_rresp (out, 2), o_axi_rvalid (out, 1) and i_axi_rready (in, 1), forming the upstream read-data channel to the IFU.
REQ-008 SHALL have ports o_axi_araddr (out, 32), o_axi_arvalid (out, 1) and i_axi_arready (in, 1), forming the downstream read-address channel to the arbiter's port 0.
REQ-009 SHALL have ports i_axi_rdata (in, 32), i_axi_rresp (in, 2), i_axi_rvalid (in, 1) and o_axi_rready (out, 1), forming the downstream read-data channel.
REQ-010 SHALL have ports o_perf_hit (out, 32) and o_perf_miss (out, 32), the hit and miss counters.

Function
REQ-011 SHALL implement states IDLE, LOOKUP, REFILL_AR, REFILL_R, BYPASS_AR, BYPASS_R and RESP.
REQ-012 SHALL decompose the address as offset = log2(LINE_WORDS*4) bits, index = log2(NUM_LINES) bits, and tag = the remaining upper bits.
REQ-013 SHALL drive o_axi_arready=1 only in IDLE; on handshake it SHALL latch the address and go to LOOKUP, or to BYPASS_AR if the address is outside 0x8000_0000-0x8FFF_FFFF.
REQ-014 LOOKUP SHALL compare the tag and valid bit; on a hit it SHALL go to RESP with the selected word, so o_axi_rvalid asserts 2 cycles after the AR handshake.
REQ-015 On a miss, LOOKUP SHALL go to REFILL_AR with the beat counter at 0 and the base address equal to the line-aligned address.
REQ-016 REFILL_AR SHALL drive o_axi_arvalid with address base+4*beat and hold it until i_axi_arready, then go to REFILL_R; exactly one read SHALL be outstanding at a time.
REQ-017 REFILL_R SHALL drive o_axi_rready=1; on i_axi_rvalid with rresp=0 it SHALL write the word at that beat's position; when beat==LINE_WORDS-1 it SHALL write the tag, set the valid bit and go to RESP, otherwise it SHALL increment beat and return to REFILL_AR.
REQ-018 A refill beat with nonzero rresp SHALL abort the refill, leave the line invalid, and enter RESP with rdata=0 and that rresp.
REQ-019 The BYPASS path SHALL perform one downstream read of the exact address, SHALL NOT update any array, and SHALL forward rdata/rresp to RESP.
REQ-020 RESP SHALL hold o_axi_rvalid=1 with stable rdata/rresp until i_axi_rready, then return to IDLE; the next AR SHALL NOT be accepted in the same cycle.
REQ-021 i_flush SHALL clear all valid bits on the next edge in any state; if a refill is in progress, that refill SHALL still return data but SHALL NOT set its valid bit.
REQ-022 Outputs not named active in the current state SHALL be 0.

Reset
REQ-023 While i_reset=0 at a clock edge, the block SHALL set state to IDLE, clear all valid bits, beat=0 and counters=0.
REQ-024 After reset, o_axi_arready=1 and all other outputs SHALL be 0; a reset mid-refill SHALL abandon the downstream transaction without waiting for it.

Configuration
REQ-025 With YSYX_24110006_ICACHE_PERF_EN defined, o_perf_hit SHALL increment on each LOOKUP hit and o_perf_miss on each LOOKUP miss, both wrapping at 2^32.
REQ-026 Without YSYX_24110006_ICACHE_PERF_EN, no counter flops SHALL exist and both perf outputs SHALL be tied to 0.

Structure
REQ-027 The shared package ysyx_24110006_pkg SHALL hold the state enum, the cacheable base/limit constants and the AXI RESP codes (OKAY=0, SLVERR=2).
REQ-028 The tag/data/valid storage SHALL be one sub-module, ysyx_24110006_icache_array, with a combinational read and a single synchronous write port.

Verification
REQ-029 After reset, read 0x8000_0010 -> 4 downstream ARs at 0x8000_0010, 0x8000_0014, 0x8000_0018, 0x8000_001C, then rdata = word 0, miss=1.
REQ-030 Immediately re-read 0x8000_0014 -> no downstream AR, rvalid 2 cycles after handshake, hit=1.
REQ-031 Read 0x8000_0110 (same index, different tag, NUM_LINES=16) -> refill evicts the line; a following read of 0x8000_0010 misses again.
REQ-032 Read 0xA000_0048 -> exactly one downstream AR at 0xA000_0048, with data forwarded unchanged and no counter change.
REQ-033 Return rresp=2 on beat 2 of a refill -> upstream rresp=2, rdata=0, and the line is re-fetched on the next access.
REQ-034 Pulse i_flush during REFILL_R, then re-read the same address -> a new miss occurs; holding i_axi_rready=0 for 5 cycles in RESP keeps rvalid and rdata stable.
